i2s_tx_master: RTL and testbench

Parametrised I2S/TDM serial-audio transmitter clocked entirely from mclk. It generates bclk and lrclk itself by division and accepts whole frames through a valid/ready handshake into a one-entry holding buffer. It supports 2-channel I2S, left-justified and multi-slot TDM framing, pads slots wider than the sample, and flags underruns. It sits between the audio datapath (mixer/synth) and the codec pins, and its bclk/lrclk become the codec's clock sources.

---
 rtl/i2s_pkg.sv | 29 ++
 rtl/i2s_tx_master_if.sv | 16 +
 rtl/i2s_clkgen.sv | 73 +++++++
 rtl/i2s_tx_master.sv | 131 +++++++++++++
 tb/tb_i2s_tx_master.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S/TDM transmitter: framing modes, a width
// helper and the parameter legality rule used by the top level.
package i2s_pkg;

  localparam int unsigned MODE_I2S = 0;  // MSB one bclk after the frame edge
  localparam int unsigned MODE_LJ  = 1;  // MSB on the frame edge

  // Bits needed to hold 0..v-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Legal parameter combinations for i2s_tx_master.
  function automatic logic params_ok(input int unsigned bitsize,
                                     input int unsigned slot,
                                     input int unsigned channels,
                                     input int unsigned bclk_div,
                                     input int unsigned mode);
    return (bitsize >= 8) && (bitsize <= 32) && (slot >= bitsize) &&
           ((channels == 2) || (channels == 4) || (channels == 8)) &&
           (bclk_div >= 2) && ((bclk_div % 2) == 0) && (mode <= MODE_LJ);
  endfunction

endpackage

// File: rtl/i2s_tx_master_if.sv
// Frame input handshake of the transmitter.
//   in_valid : source has a whole frame on in_data
//   in_ready : transmitter holding buffer can take it
//   in_data  : CHANNELS*BITSIZE frame, slot 0 in the low bits
interface i2s_tx_master_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/i2s_clkgen.sv
// Bit-clock / word-clock generator. Divides mclk into bclk, walks the
// in-frame bit counter and produces lrclk.
//   mclk, rst_n, confdone : clock, async reset, enable (0 = idle)
//   tick_c        : this mclk edge is a bclk falling edge
//   pre_tick_c    : the next mclk edge is a bclk falling edge
//   bit_cnt_nxt_c : bit counter value after the next tick
//   bclk, lrclk   : registered codec clocks
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned SLOT     = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned BCLK_DIV = 4,
  localparam int unsigned FRAME   = CHANNELS * SLOT,
  localparam int unsigned CNT_W   = clog2(FRAME)
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             confdone,
  output logic             tick_c,
  output logic             pre_tick_c,
  output logic [CNT_W-1:0] bit_cnt_nxt_c,
  output logic             bclk,
  output logic             lrclk
);

  localparam int unsigned DIV_W = clog2(BCLK_DIV);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;

  // Divider and bit counter; bclk decoded from the next divider value so it stays registered.
  always_comb begin
    tick_c        = confdone && (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    pre_tick_c    = confdone && (div_cnt_q == DIV_W'(BCLK_DIV - 2));
    bit_cnt_nxt_c = (bit_cnt_q == CNT_W'(FRAME - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
    div_cnt_d     = div_cnt_q + DIV_W'(1);
    bit_cnt_d     = bit_cnt_q;
    lrclk_d       = lrclk_q;
    if (!confdone) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      lrclk_d   = 1'b0;
    end else if (tick_c) begin
      div_cnt_d = '0;
      bit_cnt_d = bit_cnt_nxt_c;
      // Two channels: word select; TDM: one-bclk frame sync.
      lrclk_d   = (CHANNELS == 2) ? (bit_cnt_nxt_c >= CNT_W'(SLOT))
                                  : (bit_cnt_nxt_c == '0);
    end
    bclk_d = (div_cnt_d >= DIV_W'(BCLK_DIV / 2));
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;

endmodule

// File: rtl/i2s_tx_master.sv
// I2S / left-justified / TDM serial audio transmitter, clocked from mclk.
// A one-entry holding buffer feeds the frame register at each frame
// boundary; an empty buffer sends a zero frame and pulses underrun.
//   mclk, rst_n : clock, async active-low reset
//   confdone    : codec configured; 0 holds the block idle
//   in_bus      : frame handshake (valid/ready/data)
//   bclk, lrclk : codec bit clock and word select / frame sync
//   sdata       : serial data, MSB first
//   underrun    : one-mclk pulse when a boundary finds the buffer empty
module i2s_tx_master
  import i2s_pkg::*;
#(
  parameter int unsigned BITSIZE  = 16,
  parameter int unsigned SLOT     = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned BCLK_DIV = 4,
  parameter int unsigned MODE     = 0
) (
  input  logic           mclk,
  input  logic           rst_n,
  input  logic           confdone,
  i2s_tx_master_if.slave in_bus,
  output logic           bclk,
  output logic           lrclk,
  output logic           sdata,
  output logic           underrun
);

  localparam int unsigned DATA_W = CHANNELS * BITSIZE;
  localparam int unsigned FRAME  = CHANNELS * SLOT;
  localparam int unsigned CNT_W  = clog2(FRAME);
  localparam int unsigned IDX_W  = clog2(DATA_W);
  localparam int unsigned DLY    = (MODE == MODE_I2S) ? 1 : 0;

  if (!params_ok(BITSIZE, SLOT, CHANNELS, BCLK_DIV, MODE)) begin : g_bad_params
    $error("i2s_tx_master: illegal parameter combination");
  end

  logic             tick_c, pre_tick_c;
  logic [CNT_W-1:0] bit_cnt_nxt_c;
  logic             load_c, load_next_c, accept_c;
  int unsigned      pos_c, slot_c, bit_c;
  logic [IDX_W-1:0] idx_c;

  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic              full_q, full_d;
  logic              ready_q, ready_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;

  i2s_clkgen #(
    .SLOT     (SLOT),
    .CHANNELS (CHANNELS),
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .mclk          (mclk),
    .rst_n         (rst_n),
    .confdone      (confdone),
    .tick_c        (tick_c),
    .pre_tick_c    (pre_tick_c),
    .bit_cnt_nxt_c (bit_cnt_nxt_c),
    .bclk          (bclk),
    .lrclk         (lrclk)
  );

  // Buffer/frame handling and serialiser; ready is precomputed for the next cycle.
  always_comb begin
    load_c      = tick_c && (bit_cnt_nxt_c == CNT_W'(DLY));
    load_next_c = pre_tick_c && (bit_cnt_nxt_c == CNT_W'(DLY));
    accept_c    = in_bus.in_valid && ready_q;
    buf_d       = buf_q;
    full_d      = full_q;
    frame_d     = frame_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;
    ready_d     = 1'b0;
    pos_c       = 0;
    slot_c      = 0;
    bit_c       = 0;
    idx_c       = '0;
    if (!confdone) begin
      buf_d   = '0;
      full_d  = 1'b0;
      frame_d = '0;
      sdata_d = 1'b0;
    end else begin
      if (load_c) begin
        frame_d    = full_q ? buf_q : '0;
        underrun_d = !full_q;
        full_d     = 1'b0;
      end
      // Accept after load so a same-cycle handoff keeps the buffer full.
      if (accept_c) begin
        buf_d  = in_bus.in_data;
        full_d = 1'b1;
      end
      if (tick_c) begin
        pos_c   = (32'(bit_cnt_nxt_c) + FRAME - DLY) % FRAME;
        slot_c  = pos_c / SLOT;
        bit_c   = pos_c % SLOT;
        idx_c   = IDX_W'(slot_c * BITSIZE + BITSIZE - 1 - bit_c);
        sdata_d = (bit_c < BITSIZE) ? frame_d[idx_c] : 1'b0;
      end
      ready_d = !full_d || load_next_c;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      full_q     <= 1'b0;
      frame_q    <= '0;
      ready_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      full_q     <= full_d;
      frame_q    <= frame_d;
      ready_q    <= ready_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign in_bus.in_ready = ready_q;
  assign sdata           = sdata_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: a 2-channel I2S instance and a 4-slot 24-bit
// left-justified TDM instance run side by side against a frame-level model.
module tb_i2s_tx_master;

  localparam int unsigned MAXF = 64;
  localparam int unsigned P_BS [2] = '{16, 24};
  localparam int unsigned P_SL [2] = '{32, 32};
  localparam int unsigned P_CH [2] = '{2, 4};
  localparam int unsigned P_DV [2] = '{4, 2};
  localparam int unsigned P_MD [2] = '{0, 1};

  logic mclk = 1'b0;
  logic rst_n = 1'b1;
  logic confdone = 1'b0;

  logic bclk_a, lrclk_a, sdata_a, under_a;
  logic bclk_b, lrclk_b, sdata_b, under_b;

  i2s_tx_master_if #(.DATA_W(32)) if_a ();
  i2s_tx_master_if #(.DATA_W(96)) if_b ();

  i2s_tx_master #(.BITSIZE(16), .SLOT(32), .CHANNELS(2), .BCLK_DIV(4), .MODE(0)) u_a (
    .mclk(mclk), .rst_n(rst_n), .confdone(confdone), .in_bus(if_a),
    .bclk(bclk_a), .lrclk(lrclk_a), .sdata(sdata_a), .underrun(under_a));

  i2s_tx_master #(.BITSIZE(24), .SLOT(32), .CHANNELS(4), .BCLK_DIV(2), .MODE(1)) u_b (
    .mclk(mclk), .rst_n(rst_n), .confdone(confdone), .in_bus(if_b),
    .bclk(bclk_b), .lrclk(lrclk_b), .sdata(sdata_b), .underrun(under_b));

  always #5 mclk = ~mclk;

  logic o_bclk [2], o_lr [2], o_sd [2], o_un [2], o_rdy [2];
  assign o_bclk[0] = bclk_a;  assign o_bclk[1] = bclk_b;
  assign o_lr[0]   = lrclk_a; assign o_lr[1]   = lrclk_b;
  assign o_sd[0]   = sdata_a; assign o_sd[1]   = sdata_b;
  assign o_un[0]   = under_a; assign o_un[1]   = under_b;
  assign o_rdy[0]  = if_a.in_ready; assign o_rdy[1] = if_b.in_ready;

  // Reference model: mclk edges since enable, pending frame, frames sent per boundary.
  int unsigned ncyc;
  logic        pend_v [2];
  logic [95:0] pend_d [2];
  logic [95:0] sent [2][MAXF];
  logic        m_ready [2], m_under [2], acc_last [2];
  logic        vld [2];
  logic [95:0] dat [2];
  int          n_checks, n_err;

  task automatic chk(input string tag, input int d, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, d, $time, obs, expv);
    end
  endtask

  task automatic model_reset();
    ncyc = 0;
    for (int i = 0; i < 2; i++) begin
      pend_v[i] = 1'b0; pend_d[i] = '0; m_ready[i] = 1'b0;
      m_under[i] = 1'b0; acc_last[i] = 1'b0;
      for (int f = 0; f < int'(MAXF); f++) sent[i][f] = '0;
    end
  endtask

  function automatic logic [95:0] rnd(input int d);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    if (d == 0) r[95:32] = '0;
    return r;
  endfunction

  task automatic apply();
    if_a.in_valid = vld[0];
    if_a.in_data  = dat[0][31:0];
    if_b.in_valid = vld[1];
    if_b.in_data  = dat[1];
  endtask

  // Expected pins from elapsed bclk count and the list of sent frames.
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int unsigned dv, fr, dd, k, bc, f, p, s, b;
      int q;
      logic e_bclk, e_lr, e_sd;
      logic [95:0] tmp;
      dv = P_DV[i]; fr = P_CH[i] * P_SL[i]; dd = (P_MD[i] == 0) ? 1 : 0;
      k  = ncyc / dv; bc = k % fr;
      e_bclk = ((ncyc % dv) >= dv / 2);
      if (k == 0) e_lr = 1'b0;
      else if (P_CH[i] == 2) e_lr = (bc >= P_SL[i]);
      else e_lr = (bc == 0);
      q = int'(k) - int'(dd);
      e_sd = 1'b0;
      if (q >= 0) begin
        f = $unsigned(q) / fr; p = $unsigned(q) % fr;
        s = p / P_SL[i]; b = p % P_SL[i];
        if (b < P_BS[i] && f < MAXF) begin
          tmp  = sent[i][f] >> (s * P_BS[i] + P_BS[i] - 1 - b);
          e_sd = tmp[0];
        end
      end
      chk("bclk", i, o_bclk[i], e_bclk);
      chk("lrclk", i, o_lr[i], e_lr);
      chk("sdata", i, o_sd[i], e_sd);
      chk("underrun", i, o_un[i], m_under[i]);
      chk("in_ready", i, o_rdy[i], m_ready[i]);
    end
  endtask

  // One mclk cycle: drive, advance the model at the edge, check #1 later.
  task automatic cyc();
    logic en;
    logic acc [2];
    apply();
    en = rst_n && confdone;
    for (int i = 0; i < 2; i++) acc[i] = vld[i] && m_ready[i];
    @(posedge mclk);
    if (!en) model_reset();
    else begin
      ncyc++;
      for (int i = 0; i < 2; i++) begin
        int unsigned dv, fr, dd, nx, f;
        logic load;
        dv = P_DV[i]; fr = P_CH[i] * P_SL[i]; dd = (P_MD[i] == 0) ? 1 : 0;
        load = ((ncyc % dv) == 0) && (((ncyc / dv) % fr) == dd);
        m_under[i] = 1'b0;
        if (load) begin
          f = ((ncyc / dv) - dd) / fr;
          if (f < MAXF) sent[i][f] = pend_v[i] ? pend_d[i] : '0;
          m_under[i] = !pend_v[i];
          pend_v[i]  = 1'b0;
        end
        if (acc[i]) begin
          pend_v[i] = 1'b1;
          pend_d[i] = dat[i];
        end
        acc_last[i] = acc[i];
        nx = ncyc + 1;
        m_ready[i] = !pend_v[i] || (((nx % dv) == 0) && (((nx / dv) % fr) == dd));
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    vld[0] = 1'b0; vld[1] = 1'b0; dat[0] = '0; dat[1] = '0;
    apply();
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all();
    repeat (4) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();

    // Directed frame on both instances, then starve them.
    confdone = 1'b1;
    repeat (100) cyc();
    dat[0] = {64'd0, 16'h0F0F, 16'hA5F0};
    dat[1] = {24'h123456, 24'h000000, 24'h7FFFFF, 24'h800001};
    vld[0] = 1'b1; vld[1] = 1'b1;
    for (int t = 0; t < 600 && (vld[0] || vld[1]); t++) begin
      cyc();
      for (int i = 0; i < 2; i++) if (acc_last[i]) vld[i] = 1'b0;
    end
    for (int i = 0; i < 2; i++) chk("accept_wait", i, vld[i], 1'b0);
    repeat (3 * 256 + 20) cyc();

    // Continuous streaming of random frames.
    for (int i = 0; i < 2; i++) begin vld[i] = 1'b1; dat[i] = rnd(i); end
    repeat (6 * 256) begin
      cyc();
      for (int i = 0; i < 2; i++) if (acc_last[i]) dat[i] = rnd(i);
    end

    // confdone dropped mid-slot, then re-enabled.
    repeat (37) cyc();
    confdone = 1'b0;
    repeat (5) cyc();
    confdone = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    repeat (10) cyc();
    vld[0] = 1'b1; vld[1] = 1'b1;
    repeat (2 * 256) begin
      cyc();
      for (int i = 0; i < 2; i++) if (acc_last[i]) dat[i] = rnd(i);
    end

    // Asynchronous reset mid-slot: outputs clear without a clock edge.
    repeat (53) cyc();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) cyc();
    rst_n = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    repeat (10) cyc();

    // Random valid with data changing every cycle.
    repeat (4 * 256) begin
      for (int i = 0; i < 2; i++) begin
        vld[i] = (($urandom % 3) == 0);
        dat[i] = rnd(i);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
